mem_sram_responder: RTL
=======================

MEM_SRAM_RESPONDER -- requirements
Module: mem_sram_responder

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width; memory depth = 2^AW 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, legal 1..8, meaning cycles from head-of-queue start to data_ok.
REQ-003 SHALL have parameter QDEPTH, default 2, legal 1..4, meaning maximum outstanding accepted requests.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  1  initiator request valid.
REQ-007 wr  input  1  1 = store, 0 = load.
REQ-008 size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-009 addr  input  32  byte address.
REQ-010 wdata  input  32  store data, pre-replicated by initiator across byte lanes.
REQ-011 addr_ok  output  1  request accepted this cycle when req && addr_ok.
REQ-012 data_ok  output  1  one-cycle response pulse for the oldest accepted request.
REQ-013 rdata  output  32  load data, valid while data_ok.
REQ-014 resp_err  output  1  alignment error for the responding request, valid while data_ok.
REQ-015 outstanding  output  3  number of accepted, unresponded requests.

Function
REQ-016 addr_ok SHALL equal (outstanding < QDEPTH), ignoring a same-cycle pop.
REQ-017 Acceptance SHALL be req && addr_ok; each accepted request SHALL get exactly one data_ok, in acceptance order.
REQ-018 Word index SHALL be addr[AW+1:2]; higher address bits SHALL be ignored, giving wrap-around.
REQ-019 Misaligned SHALL mean size==3, (size==1 && addr[0]), or (size==2 && addr[1:0]!=0).
REQ-020 Byte strobe SHALL be: size 0 -> 1<<addr[1:0]; size 1 -> 4'b0011<<addr[1:0]; size 2 -> 4'b1111; misaligned -> 4'b0000.
REQ-021 An aligned store SHALL update strobed bytes from the matching wdata lanes at the acceptance clock edge.
REQ-022 A load SHALL sample the full 32-bit word at the acceptance edge and store it in the queue entry. The load therefore sees all earlier-accepted stores.
REQ-023 Each queue entry SHALL hold {rdata, err}. Stores SHALL return rdata = 0.
REQ-024 The head countdown SHALL load LATENCY-1 when an entry becomes head. It becomes head on acceptance into an empty queue, or on the pop of the previous head.
REQ-025 The countdown SHALL decrement each cycle while nonzero. data_ok SHALL assert in the cycle the head count is 0.
REQ-026 An isolated request accepted at edge T SHALL produce data_ok in the cycle after edge T+LATENCY-1. With LATENCY=1, that is the cycle immediately after acceptance.
REQ-027 Back-to-back responses SHALL be spaced exactly LATENCY cycles apart.
REQ-028 On a simultaneous accept and pop, outstanding SHALL be unchanged, and the new entry SHALL be enqueued behind the remaining entries.
REQ-029 On a simultaneous accept and pop with a single entry, the new entry SHALL become head next cycle with a freshly loaded count.
REQ-030 rdata and resp_err SHALL present the head entry during data_ok. rdata SHALL hold its last driven value otherwise.
REQ-031 resp_err SHALL be 0 when data_ok is 0.
REQ-032 The queue SHALL be a circular buffer with head/tail pointers wrapping modulo QDEPTH; full and empty SHALL be derived from outstanding.
REQ-033 req deasserting or changing while addr_ok=0 SHALL have no effect, since no handshake is implied.

Reset
REQ-034 While rst=1, addr_ok, data_ok, resp_err and outstanding SHALL be 0, rdata SHALL be 32'h0, and queue pointers and countdown SHALL be cleared.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted mid-operation SHALL discard all pending responses; no data_ok SHALL follow for requests accepted before reset.
REQ-037 addr_ok SHALL return to 1 on the first cycle after rst deasserts.

Verification
REQ-038 Store-then-load, LATENCY=2: word store 32'hDEADBEEF at 0x10, then load at 0x10 -> two data_ok pulses 2 cycles apart; second rdata = 32'hDEADBEEF; resp_err = 0.
REQ-039 Byte/half merge: word 0 at 0x20, byte store wdata 32'hAAAAAAAA at 0x21, half store wdata 32'h55555555 at 0x22, load 0x20 -> rdata = 32'h5555AA00.
REQ-040 Misalign: half store at 0x03 over existing 32'h12345678 -> data_ok with resp_err = 1; memory unchanged; later load returns 32'h12345678.
REQ-041 Backpressure, QDEPTH=2, LATENCY=3: req held high for 6 cycles -> addr_ok drops when outstanding = 2; responses in order, 3 cycles apart; outstanding never exceeds 2.
REQ-042 Reset mid-flight: 2 requests outstanding, pulse rst -> outstanding = 0, no data_ok; addr_ok = 1 next cycle; earlier store data still readable.
REQ-043 Wrap: AW=10, store 32'h1 at 0x1000, load at 0x0 -> rdata = 32'h1.

Source files
------------

// File: rtl/mem_sram_responder.sv
// mem_sram_responder: SRAM-backed load/store responder with in-order response queue and fixed head latency
module mem_sram_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        resp_err,
  output logic [2:0]  outstanding
);
  localparam logic [1:0] LAST    = 2'(QDEPTH - 1);
  localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);
  localparam logic [2:0] QD      = 3'(QDEPTH);
  logic [31:0] mem [2**AW];
  logic [31:0] qd_q [4];
  logic [31:0] qd_d [4];
  logic [3:0]  qe_q, qe_d;
  logic [1:0]  head_q, head_d, tail_q, tail_d;
  logic [2:0]  cnt_q, cnt_d, cd_q, cd_d;
  logic [31:0] rdata_q, rdata_d;
  logic        accept, mis, new_head;
  logic [3:0]  strb;
  logic [AW-1:0] idx;
  logic        unused_hi;
  assign idx       = addr[AW+1:2];
  assign unused_hi = &{1'b0, addr[31:AW+2]};
  assign mis  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
  assign strb = mis ? 4'b0000 : size == 2'd0 ? 4'b0001 << addr[1:0] : size == 2'd1 ? 4'b0011 << addr[1:0] : 4'b1111;
  assign addr_ok     = !rst && cnt_q < QD;
  assign accept      = req && addr_ok;
  assign data_ok     = !rst && cnt_q != 3'd0 && cd_q == 3'd0;
  assign rdata       = data_ok ? qd_q[head_q] : rdata_q;
  assign resp_err    = data_ok && qe_q[head_q];
  assign outstanding = cnt_q;
  // an entry becomes head when it lands in an empty queue or when its predecessor pops
  assign new_head = (accept && cnt_q == 3'd0) || (data_ok && (cnt_q > 3'd1 || accept));
  always_comb begin
    qd_d = qd_q;
    qe_d = qe_q;
    if (accept) begin
      qd_d[tail_q] = wr ? 32'h0 : mem[idx];
      qe_d[tail_q] = mis;
    end
    tail_d  = accept ? (tail_q == LAST ? 2'd0 : tail_q + 2'd1) : tail_q;
    head_d  = data_ok ? (head_q == LAST ? 2'd0 : head_q + 2'd1) : head_q;
    cnt_d   = cnt_q + {2'b00, accept} - {2'b00, data_ok};
    cd_d    = new_head ? CD_INIT : cd_q != 3'd0 ? cd_q - 3'd1 : cd_q;
    rdata_d = rdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      qd_q    <= '{default: '0};
      qe_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      cd_q    <= '0;
      rdata_q <= '0;
    end else begin
      qd_q    <= qd_d;
      qe_q    <= qe_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      cd_q    <= cd_d;
      rdata_q <= rdata_d;
    end
  end
  // storage survives reset, so it lives outside the reset domain
  always_ff @(posedge clk) begin
    if (accept && wr)
      for (int i = 0; i < 4; i++)
        if (strb[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
endmodule
